// File: rtl/chunked_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : chunked_subtractor
// Brief    : Multi-cycle D = A - B - borrow_in, one CHUNK-bit ripple-borrow
//            slice per clock, valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int c_numChunks = WIDTH / CHUNK;
    localparam int c_idxW      = (c_numChunks > 1) ? $clog2(c_numChunks) : 1;
    localparam logic [c_idxW-1:0] c_lastIdx = c_idxW'(c_numChunks - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_widthCheck
            $error("chunked_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_borrow;
    logic [c_idxW-1:0] r_idx;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrowOut;
    logic              r_overflow;
    logic              r_zero;

    logic [CHUNK-1:0]  w_aChunk;
    logic [CHUNK-1:0]  w_bChunk;
    logic [CHUNK-1:0]  w_sliceDiff;
    logic              w_sliceBorrow;
    logic [WIDTH-1:0]  w_diffNext;
    logic              w_lastChunk;

    assign w_aChunk    = r_a[r_idx*CHUNK +: CHUNK];
    assign w_bChunk    = r_b[r_idx*CHUNK +: CHUNK];
    assign w_lastChunk = (r_idx == c_lastIdx);

    // One ripple-borrow slice; the borrow is a loop-local variable so the
    // chain stays a single combinational cone bounded by CHUNK.
    always_comb begin
        logic v_bw;
        w_sliceDiff = '0;
        v_bw        = r_borrow;
        for (int i = 0; i < CHUNK; i++) begin
            w_sliceDiff[i] = w_aChunk[i] ^ w_bChunk[i] ^ v_bw;
            v_bw = (~w_aChunk[i] & w_bChunk[i]) |
                   (~(w_aChunk[i] ^ w_bChunk[i]) & v_bw);
        end
        w_sliceBorrow = v_bw;
    end

    // Full result as it will look after this edge, so final flags see the
    // freshly computed top chunk.
    always_comb begin
        w_diffNext = r_diff;
        w_diffNext[r_idx*CHUNK +: CHUNK] = w_sliceDiff;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (w_lastChunk) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_borrow    <= 1'b0;
            r_idx       <= '0;
            r_diff      <= '0;
            r_borrowOut <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= borrow_in;
                        r_idx    <= '0;
                    end
                end
                S_RUN: begin
                    r_diff   <= w_diffNext;
                    r_borrow <= w_sliceBorrow;
                    if (w_lastChunk) begin
                        r_idx       <= '0;
                        r_borrowOut <= w_sliceBorrow;
                        r_overflow  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                                       (w_diffNext[WIDTH-1] ^ r_a[WIDTH-1]);
                        r_zero      <= (w_diffNext == '0);
                    end else begin
                        r_idx <= r_idx + c_idxW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrowOut;
    assign overflow   = r_overflow;
    assign zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_chunked_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_subtractor
// Brief    : Self-checking bench for chunked_subtractor (WIDTH=16, CHUNK=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_subtractor;

    localparam int W = 16;
    localparam int N = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          borrow_in = 1'b0;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  diff;
    logic          borrow_out;
    logic          overflow;
    logic          zero;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } res_t;

    always #5 clk = ~clk;

    chunked_subtractor #(.WIDTH(W), .CHUNK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    // Reference: plain integer arithmetic, unsigned and signed views.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        res_t r;
        int ud;
        int sd;
        ud   = int'(ma) - int'(mb) - int'(mbin);
        sd   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        r.d  = W'(ud);
        r.bo = (ud < 0);
        r.ov = (sd < -32768) || (sd > 32767);
        r.z  = (r.d == '0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits (bounded) for out_valid; lat = -1 on timeout.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                          output res_t got, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        a         = oa;
        b         = ob;
        borrow_in = obin;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat       = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        got = {diff, borrow_out, overflow, zero};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        checks++;
        if ({diff, borrow_out, overflow, zero} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: diff=%h bo=%b ov=%b z=%b, expected all 0", diff, borrow_out, overflow, zero);
        end
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vbin;
        logic [W-1:0] vdiff;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[6];
        res_t got;
        res_t exp;
        int   lat;
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000};
        vecs[4] = '{16'h5555, 16'h5554, 1'b1, 16'h0000};
        vecs[5] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF};
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, got, lat);
            exp = model(vecs[i].va, vecs[i].vb, vecs[i].vbin);
            checks++;
            if (lat !== N) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, expected %0d", i, lat, N);
            end
            checks++;
            if (got !== exp || got.d !== vecs[i].vdiff) begin
                failures++;
                $display("FAIL directed[%0d]: got diff=%h bo=%b ov=%b z=%b, expected diff=%h bo=%b ov=%b z=%b",
                         i, got.d, got.bo, got.ov, got.z, vecs[i].vdiff, exp.bo, exp.ov, exp.z);
            end
            tick();
        end
    endtask

    task automatic test_random();
        res_t got;
        res_t exp;
        int   lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rbin;
        for (int i = 0; i < 24; i++) begin
            ra   = W'($urandom);
            rb   = (i % 4 == 0) ? ra : W'($urandom);
            rbin = 1'($urandom);
            run_op(ra, rb, rbin, got, lat);
            exp = model(ra, rb, rbin);
            checks++;
            if (lat !== N || got !== exp) begin
                failures++;
                $display("FAIL random[%0d] a=%h b=%h bin=%b: got lat=%0d diff=%h bo=%b ov=%b z=%b, expected lat=%0d diff=%h bo=%b ov=%b z=%b",
                         i, ra, rb, rbin, lat, got.d, got.bo, got.ov, got.z, N, exp.d, exp.bo, exp.ov, exp.z);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        res_t got;
        res_t exp;
        int   lat;
        out_ready = 1'b0;
        run_op(16'hBEEF, 16'h1234, 1'b1, got, lat);
        exp = model(16'hBEEF, 16'h1234, 1'b1);
        checks++;
        if (lat !== N || got !== exp) begin
            failures++;
            $display("FAIL backpressure_result: got lat=%0d diff=%h, expected lat=%0d diff=%h", lat, got.d, N, exp.d);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {diff, borrow_out, overflow, zero} !== exp) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b diff=%h, expected 1 0 %h",
                         i, out_valid, in_ready, diff, exp.d);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {diff, borrow_out, overflow, zero} !== exp) begin
            failures++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b diff=%h, expected 0 1 %h",
                     out_valid, in_ready, diff, exp.d);
        end
    endtask

    task automatic test_run_ignore();
        res_t exp;
        int   lat;
        a         = 16'h4321;
        b         = 16'h0F0F;
        borrow_in = 1'b0;
        exp       = model(16'h4321, 16'h0F0F, 1'b0);
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat       = 2;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== N || {diff, borrow_out, overflow, zero} !== exp) begin
            failures++;
            $display("FAIL run_ignore: got lat=%0d diff=%h bo=%b, expected lat=%0d diff=%h bo=%b",
                     lat, diff, borrow_out, N, exp.d, exp.bo);
        end
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL run_ignore_no_extra_op: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t exp;
        int   cyc;
        int   lastDone;
        int   nDone;
        logic pushed;
        cyc       = 0;
        lastDone  = -1;
        nDone     = 0;
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'($urandom);
        in_valid  = 1'b1;
        while (nDone < 4 && cyc < 80) begin
            pushed = 1'b0;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_result: diff=%h with no operation pending", diff);
                end else begin
                    exp = q.pop_front();
                    if ({diff, borrow_out, overflow, zero} !== exp) begin
                        failures++;
                        $display("FAIL b2b_result[%0d]: got diff=%h bo=%b ov=%b z=%b, expected diff=%h bo=%b ov=%b z=%b",
                                 nDone, diff, borrow_out, overflow, zero, exp.d, exp.bo, exp.ov, exp.z);
                    end
                end
                if (lastDone >= 0) begin
                    checks++;
                    if (cyc - lastDone !== N + 2) begin
                        failures++;
                        $display("FAIL b2b_throughput: got %0d cycles between results, expected %0d", cyc - lastDone, N + 2);
                    end
                end
                lastDone = cyc;
                nDone++;
                if (nDone == 4) in_valid = 1'b0;
            end
            if (in_ready && in_valid) begin
                q.push_back(model(a, b, borrow_in));
                pushed = 1'b1;
            end
            tick();
            cyc++;
            if (pushed) begin
                a         = W'($urandom);
                b         = W'($urandom);
                borrow_in = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nDone !== 4) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d results, expected 4", nDone);
        end
    endtask

    task automatic test_reset_midrun();
        res_t got;
        res_t exp;
        int   lat;
        logic sawValid;
        a         = 16'hFFFF;
        b         = 16'h0001;
        borrow_in = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {diff, borrow_out, overflow, zero} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b diff=%h bo=%b ov=%b z=%b, expected 1 0 0000 0 0 0",
                     in_ready, out_valid, diff, borrow_out, overflow, zero);
        end
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_result: out_valid seen after abort, expected none");
        end
        run_op(16'h0003, 16'h0001, 1'b0, got, lat);
        exp = model(16'h0003, 16'h0001, 1'b0);
        checks++;
        if (lat !== N || got !== exp || got.d !== 16'h0002) begin
            failures++;
            $display("FAIL midrun_next_op: got lat=%0d diff=%h, expected lat=%0d diff=0002", lat, got.d, N);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_run_ignore();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
